// File: rtl/moore_state_register.sv
// ---------------------------------------------------------------------------
// moore_state_register
//
// Parametrised state-register stage for Moore machines. It sits between the
// next-state combinational logic and the output logic of an FSM and captures
// the next state on every rising clock edge. Around the plain register it adds
// a capture enable, a synchronous force-load, recovery from illegal encodings,
// a registered one-hot decode, a state-change strobe and a saturating counter
// of cycles spent in the current state.
//
// Parameters
//   STATE_W      width of the state vector (>= 1)
//   NUM_STATES   number of legal encodings 0..NUM_STATES-1 (<= 2**STATE_W)
//   RESET_STATE  state loaded on reset and on illegal recovery (< NUM_STATES)
//   DWELL_W      width of the dwell counter (>= 1)
//
// Ports
//   inputClk       in   1            clock, rising edge
//   inputR         in   1            synchronous active-high reset
//   inputEn        in   1            capture enable for inputY
//   inputY         in   STATE_W      next state from the next-state logic
//   inputLoad      in   1            force-load strobe (beats inputEn)
//   inputLoadVal   in   STATE_W      value used by a force-load
//   outputy        out  STATE_W      current state
//   outputOneHot   out  NUM_STATES   registered one-hot decode of outputy
//   outputChanged  out  1            strobe: outputy differs from last cycle
//   outputDwell    out  DWELL_W      cycles in the current state, saturating
//   outputIllegal  out  1            strobe: an illegal value was rejected
// ---------------------------------------------------------------------------
module moore_state_register #(
    parameter int STATE_W     = 2,
    parameter int NUM_STATES  = 4,
    parameter int RESET_STATE = 0,
    parameter int DWELL_W     = 8
) (
    input  logic                  inputClk,
    input  logic                  inputR,
    input  logic                  inputEn,
    input  logic [STATE_W-1:0]    inputY,
    input  logic                  inputLoad,
    input  logic [STATE_W-1:0]    inputLoadVal,
    output logic [STATE_W-1:0]    outputy,
    output logic [NUM_STATES-1:0] outputOneHot,
    output logic                  outputChanged,
    output logic [DWELL_W-1:0]    outputDwell,
    output logic                  outputIllegal
);

    localparam logic [STATE_W-1:0]    RESET_VAL    = STATE_W'(RESET_STATE);
    localparam logic [STATE_W:0]      NUM_STATES_V = (STATE_W + 1)'(NUM_STATES);
    localparam logic [NUM_STATES-1:0] ONEHOT_ONE   = NUM_STATES'(1);
    localparam logic [NUM_STATES-1:0] RESET_ONEHOT = ONEHOT_ONE << RESET_STATE;
    localparam logic [DWELL_W-1:0]    DWELL_MAX    = '1;
    // When every encoding is legal the range check folds away entirely.
    localparam bit                    ALL_LEGAL    = (NUM_STATES == (1 << STATE_W));

    logic [STATE_W-1:0]    candidate;
    logic                  illegalNext;
    logic [STATE_W-1:0]    stateNext;
    logic                  changedNext;
    logic [NUM_STATES-1:0] oneHotNext;
    logic [DWELL_W-1:0]    dwellNext;

    // Next-value logic. The candidate is chosen by load > enable > hold, and
    // the illegal check is applied to the candidate so that both the load and
    // the enable path are protected. A hold can never be illegal because the
    // register only ever holds legal values. The dwell counter restarts on any
    // real change and on every load cycle, even one that reloads the same
    // value, so a force-load always marks a fresh entry into the state.
    always_comb begin
        candidate   = outputy;
        illegalNext = 1'b0;
        stateNext   = outputy;
        changedNext = 1'b0;
        oneHotNext  = '0;
        dwellNext   = outputDwell;

        if (inputLoad) begin
            candidate = inputLoadVal;
        end else if (inputEn) begin
            candidate = inputY;
        end

        if (!ALL_LEGAL) begin
            illegalNext = ({1'b0, candidate} >= NUM_STATES_V);
        end

        stateNext   = illegalNext ? RESET_VAL : candidate;
        changedNext = (stateNext != outputy);

        for (int i = 0; i < NUM_STATES; i++) begin
            oneHotNext[i] = (stateNext == STATE_W'(i));
        end

        if (changedNext || inputLoad) begin
            dwellNext = '0;
        end else if (outputDwell != DWELL_MAX) begin
            dwellNext = outputDwell + 1'b1;
        end
    end

    // State register. Reset is synchronous and overrides load and enable in
    // the same cycle, leaving no strobes behind, so the first cycle after
    // reset is an ordinary hold in RESET_STATE. All side outputs are
    // registered from the same next-state value, so they line up with
    // outputy on the same edge.
    always_ff @(posedge inputClk) begin
        if (inputR) begin
            outputy       <= RESET_VAL;
            outputOneHot  <= RESET_ONEHOT;
            outputChanged <= 1'b0;
            outputDwell   <= '0;
            outputIllegal <= 1'b0;
        end else begin
            outputy       <= stateNext;
            outputOneHot  <= oneHotNext;
            outputChanged <= changedNext;
            outputDwell   <= dwellNext;
            outputIllegal <= illegalNext;
        end
    end

endmodule

// File: tb/tb_moore_state_register.sv
// ---------------------------------------------------------------------------
// tb_moore_state_register
//
// Directed self-checking bench. Three instances share one set of inputs:
//   dutA  STATE_W=2, NUM_STATES=4, RESET_STATE=0, DWELL_W=8
//   dutB  same but DWELL_W=3 (saturation)
//   dutC  same but NUM_STATES=3 (illegal recovery)
// ---------------------------------------------------------------------------
module tb_moore_state_register;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       en = 1'b0;
    logic [1:0] y = '0;
    logic       load = 1'b0;
    logic [1:0] loadVal = '0;

    logic [1:0] yA, yB, yC;
    logic [3:0] ohA, ohB;
    logic [2:0] ohC;
    logic       chA, chB, chC;
    logic [7:0] dwA, dwC;
    logic [2:0] dwB;
    logic       ilA, ilB, ilC;

    int testsRun = 0;
    int testsFailed = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    moore_state_register #(.STATE_W(2), .NUM_STATES(4), .RESET_STATE(0), .DWELL_W(8)) dutA (
        .inputClk(clk), .inputR(r), .inputEn(en), .inputY(y),
        .inputLoad(load), .inputLoadVal(loadVal),
        .outputy(yA), .outputOneHot(ohA), .outputChanged(chA),
        .outputDwell(dwA), .outputIllegal(ilA)
    );

    moore_state_register #(.STATE_W(2), .NUM_STATES(4), .RESET_STATE(0), .DWELL_W(3)) dutB (
        .inputClk(clk), .inputR(r), .inputEn(en), .inputY(y),
        .inputLoad(load), .inputLoadVal(loadVal),
        .outputy(yB), .outputOneHot(ohB), .outputChanged(chB),
        .outputDwell(dwB), .outputIllegal(ilB)
    );

    moore_state_register #(.STATE_W(2), .NUM_STATES(3), .RESET_STATE(0), .DWELL_W(8)) dutC (
        .inputClk(clk), .inputR(r), .inputEn(en), .inputY(y),
        .inputLoad(load), .inputLoadVal(loadVal),
        .outputy(yC), .outputOneHot(ohC), .outputChanged(chC),
        .outputDwell(dwC), .outputIllegal(ilC)
    );

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        r = 1'b1; en = 1'b0; load = 1'b0;
        step();
        r = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1; en = 1'b1; y = 2'd3; load = 1'b0;
        step();
        r = 1'b0; en = 1'b0;
        testsRun++;
        if (yA !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_y got %0d expected 0", yA); end
        testsRun++;
        if (ohA !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_onehot got %b expected 0001", ohA); end
        testsRun++;
        if (chA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_changed got %b expected 0", chA); end
        testsRun++;
        if (dwA !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_dwell got %0d expected 0", dwA); end
        testsRun++;
        if (ilA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_illegal got %b expected 0", ilA); end
        testsRun++;
        if (ohC !== 3'b001) begin testsFailed++; $display("[TB] FAIL reset_onehotC got %b expected 001", ohC); end
    endtask

    task automatic test_enable();
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] oh  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        doReset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            y = seq[i];
            step();
            testsRun++;
            if (yA !== seq[i]) begin testsFailed++; $display("[TB] FAIL enable_y[%0d] got %0d expected %0d", i, yA, seq[i]); end
            testsRun++;
            if (chA !== 1'b1) begin testsFailed++; $display("[TB] FAIL enable_changed[%0d] got %b expected 1", i, chA); end
            testsRun++;
            if (dwA !== 8'd0) begin testsFailed++; $display("[TB] FAIL enable_dwell[%0d] got %0d expected 0", i, dwA); end
            testsRun++;
            if (ohA !== oh[i]) begin testsFailed++; $display("[TB] FAIL enable_onehot[%0d] got %b expected %b", i, ohA, oh[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        logic [2:0] expB;
        doReset();
        for (int k = 1; k <= 10; k++) begin
            step();
            expB = (k > 7) ? 3'd7 : 3'(k);
            testsRun++;
            if (dwB !== expB) begin testsFailed++; $display("[TB] FAIL hold_dwellB[%0d] got %0d expected %0d", k, dwB, expB); end
            testsRun++;
            if (chB !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_changedB[%0d] got %b expected 0", k, chB); end
            testsRun++;
            if (dwA !== 8'(k)) begin testsFailed++; $display("[TB] FAIL hold_dwellA[%0d] got %0d expected %0d", k, dwA, k); end
        end
        // Long hold: the 8-bit counter must stop at 255.
        for (int k = 0; k < 300; k++) step();
        testsRun++;
        if (dwA !== 8'd255) begin testsFailed++; $display("[TB] FAIL hold_saturateA got %0d expected 255", dwA); end
        testsRun++;
        if (yA !== 2'd0) begin testsFailed++; $display("[TB] FAIL hold_y got %0d expected 0", yA); end
    endtask

    task automatic test_priority();
        doReset();
        en = 1'b1; y = 2'd1;
        step();
        r = 1'b1; load = 1'b1; loadVal = 2'd2; en = 1'b1; y = 2'd3;
        step();
        testsRun++;
        if (yA !== 2'd0) begin testsFailed++; $display("[TB] FAIL prio_reset_y got %0d expected 0", yA); end
        testsRun++;
        if (chA !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_reset_changed got %b expected 0", chA); end
        r = 1'b0;
        step();
        testsRun++;
        if (yA !== 2'd2) begin testsFailed++; $display("[TB] FAIL prio_load_y got %0d expected 2", yA); end
        testsRun++;
        if (chA !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_load_changed got %b expected 1", chA); end
        testsRun++;
        if (ohA !== 4'b0100) begin testsFailed++; $display("[TB] FAIL prio_load_onehot got %b expected 0100", ohA); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_illegal();
        doReset();
        en = 1'b1; y = 2'd1;
        step();
        testsRun++;
        if (yC !== 2'd1) begin testsFailed++; $display("[TB] FAIL illegal_setup_y got %0d expected 1", yC); end
        y = 2'd3;
        step();
        testsRun++;
        if (yC !== 2'd0) begin testsFailed++; $display("[TB] FAIL illegal_y got %0d expected 0", yC); end
        testsRun++;
        if (ilC !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_strobe got %b expected 1", ilC); end
        testsRun++;
        if (chC !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_changed got %b expected 1", chC); end
        testsRun++;
        if (dwC !== 8'd0) begin testsFailed++; $display("[TB] FAIL illegal_dwell got %0d expected 0", dwC); end
        testsRun++;
        if (ohC !== 3'b001) begin testsFailed++; $display("[TB] FAIL illegal_onehot got %b expected 001", ohC); end
        // The same value is legal for the 4-state instance.
        testsRun++;
        if (ilA !== 1'b0 || yA !== 2'd3) begin testsFailed++; $display("[TB] FAIL illegal_fullA got il=%b y=%0d expected il=0 y=3", ilA, yA); end
        step();
        testsRun++;
        if (ilC !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_again_strobe got %b expected 1", ilC); end
        testsRun++;
        if (chC !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_again_changed got %b expected 0", chC); end
        en = 1'b0;
        step();
        testsRun++;
        if (ilC !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_clear got %b expected 0", ilC); end
        // Illegal value through the load path.
        en = 1'b1; y = 2'd2;
        step();
        en = 1'b0; load = 1'b1; loadVal = 2'd3;
        step();
        load = 1'b0;
        testsRun++;
        if (yC !== 2'd0 || ilC !== 1'b1 || chC !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL illegal_load got y=%0d il=%b ch=%b expected y=0 il=1 ch=1", yC, ilC, chC);
        end
    endtask

    task automatic test_same_load();
        doReset();
        load = 1'b1; loadVal = 2'd2;
        step();
        load = 1'b0;
        for (int k = 0; k < 5; k++) step();
        testsRun++;
        if (yA !== 2'd2 || dwA !== 8'd5) begin testsFailed++; $display("[TB] FAIL sameload_setup got y=%0d dw=%0d expected y=2 dw=5", yA, dwA); end
        load = 1'b1; loadVal = 2'd2;
        step();
        load = 1'b0;
        testsRun++;
        if (yA !== 2'd2) begin testsFailed++; $display("[TB] FAIL sameload_y got %0d expected 2", yA); end
        testsRun++;
        if (chA !== 1'b0) begin testsFailed++; $display("[TB] FAIL sameload_changed got %b expected 0", chA); end
        testsRun++;
        if (dwA !== 8'd0) begin testsFailed++; $display("[TB] FAIL sameload_dwell got %0d expected 0", dwA); end
        step();
        testsRun++;
        if (dwA !== 8'd1) begin testsFailed++; $display("[TB] FAIL sameload_after got %0d expected 1", dwA); end
    endtask

    task automatic test_back_to_back();
        doReset();
        en = 1'b1; y = 2'd3;
        step();
        r = 1'b1; y = 2'd1;
        step();
        testsRun++;
        if (yA !== 2'd0 || chA !== 1'b0 || dwA !== 8'd0 || ilA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset got y=%0d ch=%b dw=%0d il=%b expected 0 0 0 0", yA, chA, dwA, ilA);
        end
        r = 1'b0; en = 1'b0;
        step();
        testsRun++;
        if (yA !== 2'd0 || chA !== 1'b0 || dwA !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL postreset_hold got y=%0d ch=%b dw=%0d expected 0 0 1", yA, chA, dwA);
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_hold();
        test_priority();
        test_illegal();
        test_same_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
